// File: rtl/tt_ternary_pkg.sv
// Shared definitions for the ternary matrix-vector multiply stage: sizes,
// weight encoding, FSM states and output saturation.
package tt_ternary_pkg;

  localparam int MAX_IN_LEN  = 12;
  localparam int MAX_OUT_LEN = 6;
  localparam int WIDTH       = 2;
  localparam int IN_BITS     = 8;
  localparam int ACC_BITS    = IN_BITS + $clog2(MAX_IN_LEN);
  localparam int OUT_BITS    = 8;
  localparam int WT_BITS     = WIDTH * MAX_IN_LEN * MAX_OUT_LEN;
  localparam int IN_IDX_W    = $clog2(MAX_IN_LEN);
  localparam int OUT_IDX_W   = $clog2(MAX_OUT_LEN);

  // 2'b10 is also treated as zero; only these two codes are non-zero.
  localparam logic [WIDTH-1:0] W_ZERO = 2'b00;
  localparam logic [WIDTH-1:0] W_POS  = 2'b01;
  localparam logic [WIDTH-1:0] W_NEG  = 2'b11;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam logic signed [ACC_BITS-1:0] SAT_HI = ACC_BITS'((1 << (OUT_BITS - 1)) - 1);
  localparam logic signed [ACC_BITS-1:0] SAT_LO = ~SAT_HI;

  function automatic logic signed [OUT_BITS-1:0] sat_to_out(
    input logic signed [ACC_BITS-1:0] acc
  );
    logic signed [OUT_BITS-1:0] res;
    if (acc > SAT_HI)      res = SAT_HI[OUT_BITS-1:0];
    else if (acc < SAT_LO) res = SAT_LO[OUT_BITS-1:0];
    else                   res = acc[OUT_BITS-1:0];
    return res;
  endfunction

endpackage

// File: rtl/tt_ternary_pe.sv
// Single-column ternary accumulator: adds, subtracts or holds the activation
// according to its 2-bit weight, with a synchronous clear.
module tt_ternary_pe
  import tt_ternary_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       acc_en,
  input  logic                       acc_clr,
  input  logic [WIDTH-1:0]           weight,
  input  logic signed [IN_BITS-1:0]  in_data,
  output logic signed [ACC_BITS-1:0] acc_q
);

  logic signed [ACC_BITS-1:0] acc_d;
  logic signed [ACC_BITS-1:0] in_ext;

  assign in_ext = {{(ACC_BITS - IN_BITS){in_data[IN_BITS-1]}}, in_data};

  // NOTE: acc_d gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      case (weight)
        W_POS:   acc_d = acc_q + in_ext;
        W_NEG:   acc_d = acc_q - in_ext;
        W_ZERO:  acc_d = acc_q;
        default: acc_d = acc_q;
      endcase
    end
  end

  // NOTE: the accumulator is reset because a reset must discard any partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/tt_ternary_mvm.sv
// Ternary matrix-vector multiply: accumulates one activation per cycle into
// MAX_OUT_LEN column accumulators, then streams the saturated results out.
module tt_ternary_mvm
  import tt_ternary_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [WT_BITS-1:0]         ui_weights,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_BITS-1:0]  in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_BITS-1:0] out_data,
  output logic                       out_last
);

  localparam logic [IN_IDX_W-1:0]  LAST_IN  = IN_IDX_W'(MAX_IN_LEN - 1);
  localparam logic [OUT_IDX_W-1:0] LAST_OUT = OUT_IDX_W'(MAX_OUT_LEN - 1);

  state_e                   state_q, state_d;
  logic [IN_IDX_W-1:0]      in_idx_q, in_idx_d;
  logic [OUT_IDX_W-1:0]     out_idx_q, out_idx_d;
  logic                     in_accept, out_accept, acc_clr;
  logic signed [ACC_BITS-1:0] acc [MAX_OUT_LEN];
  logic signed [ACC_BITS-1:0] acc_sel;

  // Handshake outputs depend only on registered state and ena, never on valid/ready inputs.
  assign in_ready   = rst_n & ena & (state_q == ACCUM);
  assign out_valid  = ena & (state_q == DRAIN);
  assign out_last   = out_valid & (out_idx_q == LAST_OUT);
  assign in_accept  = in_valid & in_ready;
  assign out_accept = out_valid & out_ready;

  always_comb begin
    acc_sel = '0;
    for (int o = 0; o < MAX_OUT_LEN; o++) begin
      if (out_idx_q == OUT_IDX_W'(o)) acc_sel = acc[o];
    end
  end

  assign out_data = out_valid ? sat_to_out(acc_sel) : '0;

  always_comb begin
    state_d   = state_q;
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    acc_clr   = 1'b0;
    case (state_q)
      ACCUM: begin
        if (in_accept) begin
          if (in_idx_q == LAST_IN) begin
            state_d   = DRAIN;
            in_idx_d  = '0;
            out_idx_d = '0;
          end else begin
            in_idx_d = in_idx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_accept) begin
          if (out_idx_q == LAST_OUT) begin
            state_d   = ACCUM;
            out_idx_d = '0;
            acc_clr   = 1'b1;
          end else begin
            out_idx_d = out_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      in_idx_q  <= '0;
      out_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
    end
  end

  for (genvar o = 0; o < MAX_OUT_LEN; o++) begin : g_col
    tt_ternary_pe u_pe (
      .clk     (clk),
      .rst_n   (rst_n),
      .acc_en  (in_accept),
      .acc_clr (acc_clr),
      .weight  (ui_weights[WIDTH*(o*MAX_IN_LEN + int'(in_idx_q)) +: WIDTH]),
      .in_data (in_data),
      .acc_q   (acc[o])
    );
  end

endmodule

// File: tb/tb_tt_ternary_mvm.sv
// Bench for tt_ternary_mvm: directed and random vectors against a plain
// sum-of-products reference with output clamping.
module tb_tt_ternary_mvm;
  import tt_ternary_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       ena;
  logic [WT_BITS-1:0]         ui_weights;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [IN_BITS-1:0]  in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [OUT_BITS-1:0] out_data;
  logic                       out_last;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [1:0] wt [MAX_IN_LEN][MAX_OUT_LEN];
  int         xs [MAX_IN_LEN];

  tt_ternary_mvm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .ui_weights (ui_weights),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: signed dot product of the activations with a weight column, clamped.
  function automatic int ref_out(input int o);
    int s = 0;
    int hi = (1 << (OUT_BITS - 1)) - 1;
    int lo = -(1 << (OUT_BITS - 1));
    for (int i = 0; i < MAX_IN_LEN; i++) begin
      if (wt[i][o] == 2'b01)      s = s + xs[i];
      else if (wt[i][o] == 2'b11) s = s - xs[i];
    end
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

  task automatic pack_weights();
    for (int i = 0; i < MAX_IN_LEN; i++)
      for (int o = 0; o < MAX_OUT_LEN; o++)
        ui_weights[WIDTH*(o*MAX_IN_LEN + i) +: WIDTH] = wt[i][o];
  endtask

  task automatic fill_weights(input int code);
    for (int i = 0; i < MAX_IN_LEN; i++)
      for (int o = 0; o < MAX_OUT_LEN; o++)
        wt[i][o] = (code < 0) ? 2'($urandom_range(0, 3)) : 2'(code);
    pack_weights();
  endtask

  task automatic do_freeze(input string tag);
    ena = 1'b0;
    repeat (3) begin
      in_valid  = 1'b1;
      in_data   = 8'($urandom);
      out_ready = 1'b1;
      #1;
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_last"}, out_last, 0);
      @(negedge clk);
    end
    ena = 1'b1;
  endtask

  // Feeds xs, drains all results and compares them in order. bp=1 applies 1,0,0 out_ready.
  task automatic run_vec(input string name, input int bp, input bit freeze);
    int  expv [MAX_OUT_LEN];
    int  k, n, start;
    bit  froze;
    for (int o = 0; o < MAX_OUT_LEN; o++) expv[o] = ref_out(o);
    start = cyc;
    for (int i = 0; i < MAX_IN_LEN; i++) begin
      if (freeze && i == 6) do_freeze({name, "_frz_acc"});
      ena      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'(xs[i]);
      #1;
      check({name, "_acc_in_ready"}, in_ready, 1);
      @(negedge clk);
    end
    k = 0;
    n = 0;
    froze = 1'b0;
    while (k < MAX_OUT_LEN && n < 100) begin
      if (freeze && k == 2 && !froze) begin
        froze = 1'b1;
        do_freeze({name, "_frz_drain"});
      end
      in_data = 8'($urandom);
      #1;
      check({name, "_drain_out_valid"}, out_valid, 1);
      check({name, "_drain_in_ready"}, in_ready, 0);
      check({name, "_out_data"}, $signed(out_data), expv[k]);
      check({name, "_out_last"}, out_last, (k == MAX_OUT_LEN - 1) ? 1 : 0);
      out_ready = (bp == 0) ? 1'b1 : ((n % 3) == 0);
      if (out_ready) k++;
      n++;
      @(negedge clk);
    end
    check({name, "_results_delivered"}, k, MAX_OUT_LEN);
    #1;
    check({name, "_end_in_ready"}, in_ready, 1);
    check({name, "_end_out_valid"}, out_valid, 0);
    check({name, "_end_out_data"}, $signed(out_data), 0);
    if (bp == 0 && !freeze) check({name, "_cycles"}, cyc - start, MAX_IN_LEN + MAX_OUT_LEN);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    ui_weights = '0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", $signed(out_data), 0);
    check("rst_out_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Reset mid-vector: five accepted activations must leave no trace.
    fill_weights(1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(50);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < MAX_IN_LEN; i++) xs[i] = 1;
    run_vec("midrst", 0, 1'b0);
    in_valid = 1'b0;

    // Mixed signs: +1 column, -1 column, zero column, alternating columns.
    for (int i = 0; i < MAX_IN_LEN; i++) begin
      xs[i]    = i + 1;
      wt[i][0] = 2'b01;
      wt[i][1] = 2'b11;
      wt[i][2] = (i % 2 == 0) ? 2'b00 : 2'b10;
      for (int o = 3; o < MAX_OUT_LEN; o++) wt[i][o] = (i % 2 == 0) ? 2'b01 : 2'b11;
    end
    pack_weights();
    run_vec("mixed", 0, 1'b0);
    in_valid = 1'b0;

    // Saturation at both rails.
    fill_weights(1);
    for (int i = 0; i < MAX_IN_LEN; i++) xs[i] = 100;
    run_vec("sat_hi", 0, 1'b0);
    for (int i = 0; i < MAX_IN_LEN; i++) xs[i] = -128;
    run_vec("sat_lo", 0, 1'b0);
    in_valid = 1'b0;

    // Backpressure, then ena freeze, on random data.
    fill_weights(-1);
    for (int i = 0; i < MAX_IN_LEN; i++) xs[i] = $signed(8'($urandom));
    run_vec("bp", 1, 1'b0);
    in_valid = 1'b0;
    fill_weights(-1);
    for (int i = 0; i < MAX_IN_LEN; i++) xs[i] = $signed(8'($urandom));
    run_vec("freeze", 0, 1'b1);
    in_valid = 1'b0;

    // Back-to-back vectors with in_valid and out_ready held high.
    for (int v = 0; v < 3; v++) begin
      fill_weights(-1);
      for (int i = 0; i < MAX_IN_LEN; i++) xs[i] = $signed(8'($urandom));
      run_vec("b2b", 0, 1'b0);
    end
    in_valid = 1'b0;

    // Random mix of flow-control modes.
    for (int v = 0; v < 4; v++) begin
      fill_weights(-1);
      for (int i = 0; i < MAX_IN_LEN; i++) xs[i] = $signed(8'($urandom));
      run_vec("rand", int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
